// File: rtl/fdn_axil_pkg.sv
// Shared types and constants for the FDN AXI-Lite control initiator.
package fdn_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } axil_st_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] REG_FAR = 32'd0;
    localparam logic [31:0] REG_ERR = 32'd1;
    localparam logic [31:0] REG_RST = 32'd2;

endpackage

// File: rtl/fdn_axil_master.sv
// Single-outstanding AXI-Lite initiator for the FDN core control slave, with dead-slave timeout.
// Define FDN_AXIL_IDCHK_EN to flag a returned bid/rid that differs from the issued ID.
module fdn_axil_master
    import fdn_axil_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter int                 ID_W      = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(32'hf000_0000),
    parameter int                 TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic                  cmd_wr,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [ID_W-1:0]       cmd_id,

    output logic                  rsp_vld,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_tout,
    output logic                  rsp_iderr,
    output logic                  busy,

    output logic [ADDR_W-1:0]     m_axil_awaddr,
    output logic [ID_W-1:0]       m_axil_awid,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_W-1:0]     m_axil_wdata,
    output logic [DATA_W/8-1:0]   m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    input  logic [ID_W-1:0]       m_axil_bid,

    output logic [ADDR_W-1:0]     m_axil_araddr,
    output logic [ID_W-1:0]       m_axil_arid,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_W-1:0]     m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    input  logic [ID_W-1:0]       m_axil_rid
);

    localparam int CNT_W = $clog2(TIMEOUT);

    axil_st_t             state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cmd_rdy_q, cmd_rdy_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_resp_q, rsp_resp_d;
    logic                 rsp_tout_q, rsp_tout_d;
    logic                 rsp_iderr_q, rsp_iderr_d;
    logic                 tout_hit;
    logic                 abort;
    logic                 b_iderr;
    logic                 r_iderr;

`ifdef FDN_AXIL_IDCHK_EN
    assign b_iderr = (m_axil_bid != id_q);
    assign r_iderr = (m_axil_rid != id_q);
`else
    logic unused_ids;
    assign unused_ids = ^{m_axil_bid, m_axil_rid};
    assign b_iderr    = 1'b0;
    assign r_iderr    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            id_q        <= '0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_tout_q  <= 1'b0;
            rsp_iderr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_rdy_q   <= cmd_rdy_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_tout_q  <= rsp_tout_d;
            rsp_iderr_q <= rsp_iderr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_tout_d  = rsp_tout_q;
        rsp_iderr_d = rsp_iderr_q;
        abort       = 1'b0;
        tout_hit    = (cnt_q == CNT_W'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (cmd_vld && cmd_rdy_q) begin
                    addr_d      = BASE_ADDR | cmd_addr;
                    wdata_d     = cmd_wdata;
                    id_d        = cmd_id;
                    rsp_data_d  = '0;
                    rsp_resp_d  = RESP_OKAY;
                    rsp_tout_d  = 1'b0;
                    rsp_iderr_d = 1'b0;
                    if (cmd_wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WADDR: begin
                cnt_d = cnt_q + 1'b1;
                // Address and data handshakes complete independently of each other.
                if (m_axil_awready) awvalid_d = 1'b0;
                if (m_axil_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end else if (tout_hit) begin
                    abort = 1'b1;
                end
            end
            WRESP: begin
                cnt_d = cnt_q + 1'b1;
                if (m_axil_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axil_bresp;
                    rsp_iderr_d = b_iderr;
                    state_d     = RSP;
                end else if (tout_hit) begin
                    abort = 1'b1;
                end
            end
            RADDR: begin
                cnt_d = cnt_q + 1'b1;
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    if (m_axil_rvalid) begin
                        rsp_data_d  = m_axil_rdata;
                        rsp_resp_d  = m_axil_rresp;
                        rsp_iderr_d = r_iderr;
                        state_d     = RSP;
                    end else begin
                        rready_d = 1'b1;
                        state_d  = RDATA;
                    end
                end else if (tout_hit) begin
                    abort = 1'b1;
                end
            end
            RDATA: begin
                cnt_d = cnt_q + 1'b1;
                if (m_axil_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_data_d  = m_axil_rdata;
                    rsp_resp_d  = m_axil_rresp;
                    rsp_iderr_d = r_iderr;
                    state_d     = RSP;
                end else if (tout_hit) begin
                    abort = 1'b1;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A returning response in the timeout cycle has already been taken above.
        if (abort) begin
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            rsp_tout_d = 1'b1;
            rsp_resp_d = RESP_SLVERR;
            rsp_data_d = '0;
            state_d    = RSP;
        end

        if (state_d != state_q) cnt_d = '0;
        cmd_rdy_d = (state_d == IDLE);
    end

    assign cmd_rdy        = cmd_rdy_q;
    assign busy           = (state_q != IDLE);
    assign rsp_vld        = (state_q == RSP);
    assign rsp_data       = rsp_data_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_tout       = rsp_tout_q;
    assign rsp_iderr      = rsp_iderr_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awid    = id_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arid    = id_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_fdn_axil_master.sv
// Scoreboard bench for fdn_axil_master against a configurable-latency FDN slave model.
`timescale 1ns/1ps
module tb_fdn_axil_master;
    import fdn_axil_pkg::*;

`ifdef FDN_AXIL_IDCHK_EN
    localparam logic EXP_IDERR = 1'b1;
`else
    localparam logic EXP_IDERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_vld = 1'b0, cmd_rdy, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_id = '0;
    logic        rsp_vld, rsp_tout, rsp_iderr, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;

    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  awid, arid, wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;

    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [3:0]  s_bid, s_rid;
    logic [31:0] s_rdata;

    fdn_axil_master #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_id(cmd_id),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_tout(rsp_tout),
        .rsp_iderr(rsp_iderr), .busy(busy),
        .m_axil_awaddr(awaddr), .m_axil_awid(awid), .m_axil_awvalid(awvalid), .m_axil_awready(s_awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(s_wready),
        .m_axil_bresp(s_bresp), .m_axil_bvalid(s_bvalid), .m_axil_bready(bready), .m_axil_bid(s_bid),
        .m_axil_araddr(araddr), .m_axil_arid(arid), .m_axil_arvalid(arvalid), .m_axil_arready(s_arready),
        .m_axil_rdata(s_rdata), .m_axil_rresp(s_rresp), .m_axil_rvalid(s_rvalid), .m_axil_rready(rready),
        .m_axil_rid(s_rid)
    );

    // Slave model configuration, changed only while the bus is idle or in reset.
    int   aw_dly = 0, w_dly = 0, b_dly = 1, ar_dly = 2, r_dly = 0;
    logic r_sep = 1'b0, dead = 1'b0, id_force = 1'b0;

    int          aw_c, w_c, b_c, ar_c, r_c;
    logic        aw_seen, w_seen, r_pend;
    logic [31:0] s_wa, s_wd, s_ra;
    logic [3:0]  s_wid, s_arid;
    logic [31:0] smem [4];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0; s_arready <= 1'b0; s_rvalid <= 1'b0;
            s_bresp <= 2'b00; s_rresp <= 2'b00; s_bid <= '0; s_rid <= '0; s_rdata <= '0;
            aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; r_pend <= 1'b0;
            s_wa <= '0; s_wd <= '0; s_ra <= '0; s_wid <= '0; s_arid <= '0;
            smem[0] <= 32'h0; smem[1] <= 32'h0000_00A5; smem[2] <= 32'h0; smem[3] <= 32'h0;
        end else begin
            if (s_awready) begin
                s_awready <= 1'b0; aw_seen <= 1'b1; aw_c <= 0; s_wa <= awaddr; s_wid <= awid;
            end else if (awvalid && !aw_seen && !dead) begin
                if (aw_c == aw_dly) s_awready <= 1'b1; else aw_c <= aw_c + 1;
            end
            if (s_wready) begin
                s_wready <= 1'b0; w_seen <= 1'b1; w_c <= 0; s_wd <= wdata;
            end else if (wvalid && !w_seen && !dead) begin
                if (w_c == w_dly) s_wready <= 1'b1; else w_c <= w_c + 1;
            end
            if (s_bvalid) begin
                if (bready) s_bvalid <= 1'b0;
            end else if (aw_seen && w_seen && !dead) begin
                if (b_c == b_dly) begin
                    s_bvalid <= 1'b1; s_bresp <= 2'b00; s_bid <= id_force ? 4'h0 : s_wid;
                    smem[s_wa[1:0]] <= s_wd; aw_seen <= 1'b0; w_seen <= 1'b0; b_c <= 0;
                end else b_c <= b_c + 1;
            end
            if (s_arready) begin
                s_arready <= 1'b0; r_pend <= r_sep;
            end else if (arvalid && !dead) begin
                if (ar_c == ar_dly) begin
                    s_arready <= 1'b1; ar_c <= 0; s_ra <= araddr; s_arid <= arid;
                    if (!r_sep) begin
                        s_rvalid <= 1'b1; s_rdata <= smem[araddr[1:0]]; s_rresp <= 2'b00;
                        s_rid <= id_force ? 4'h0 : arid;
                    end
                end else ar_c <= ar_c + 1;
            end
            if (r_pend && !s_rvalid) begin
                if (r_c == r_dly) begin
                    s_rvalid <= 1'b1; s_rdata <= smem[s_ra[1:0]]; s_rresp <= 2'b00;
                    s_rid <= id_force ? 4'h0 : s_arid; r_pend <= 1'b0; r_c <= 0;
                end else r_c <= r_c + 1;
            end
            if (s_rvalid && (rready || s_arready)) s_rvalid <= 1'b0;
        end
    end

    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        tout;
        logic        iderr;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_vld) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rsp: actual=rsp_vld expected=none data=%0h", rsp_data);
            end else begin
                e = sbq.pop_front();
                chk({e.nm, "_data"},  rsp_data,      e.data);
                chk({e.nm, "_resp"},  rsp_resp,      e.resp);
                chk({e.nm, "_tout"},  rsp_tout,      e.tout);
                chk({e.nm, "_iderr"}, rsp_iderr,     e.iderr);
                chk({e.nm, "_lat"},   cyc - e.acc,   e.lat);
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] id);
        int n = 0;
        @(negedge clk);
        cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_id = id; cmd_vld = 1'b1;
        while (!cmd_rdy && n < 50) begin @(negedge clk); n++; end
        chk("cmd_rdy_wait", cmd_rdy, 1'b1);
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic expect_rsp(input string nm, input logic [31:0] d, input logic [1:0] r,
                              input logic t, input logic ie, input int lat);
        exp_t e;
        e.nm = nm; e.data = d; e.resp = r; e.tout = t; e.iderr = ie; e.acc = acc_cyc; e.lat = lat;
        sbq.push_back(e);
    endtask

    task automatic at_neg(input int k);
        @(negedge clk);
        while (cyc < acc_cyc + k) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || sbq.size() != 0) && n < 100) begin @(negedge clk); n++; end
        chk("drain_busy", busy, 1'b0);
        chk("drain_sb", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_vld, busy, cmd_rdy}, 8'h00);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_ids", {awid, arid}, 8'h00);
        chk("rst_wstrb", wstrb, 4'hF);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write REG_FAR = 1: both valids together, 5-cycle response.
        issue(1'b1, REG_FAR, 32'h1, 4'h3);
        expect_rsp("wr_far", 32'h0, RESP_OKAY, 1'b0, 1'b0, 5);
        at_neg(0);
        chk("wr_far_awaddr", awaddr, 32'hf000_0000);
        chk("wr_far_valids", {awvalid, wvalid}, 2'b11);
        chk("wr_far_awid", awid, 4'h3);
        wait_idle();

        // Read back with arready and rvalid together.
        issue(1'b0, REG_FAR, 32'h0, 4'h5);
        expect_rsp("rd_far", 32'h1, RESP_OKAY, 1'b0, 1'b0, 4);
        at_neg(3);
        chk("rd_far_addr", araddr, 32'hf000_0000);
        chk("rd_far_arid", arid, 4'h5);
        chk("rd_far_pre", {arvalid, rready}, 2'b10);
        at_neg(4);
        chk("rd_far_post", {arvalid, rready}, 2'b00);
        wait_idle();

        // wready lags awready by 3 cycles.
        w_dly = 3;
        issue(1'b1, REG_RST, 32'h1234_5678, 4'h2);
        expect_rsp("wr_lag", 32'h0, RESP_OKAY, 1'b0, 1'b0, 8);
        at_neg(1); chk("wr_lag_n1", {awvalid, wvalid}, 2'b11);
        at_neg(2); chk("wr_lag_n2", {awvalid, wvalid}, 2'b01);
        at_neg(4); chk("wr_lag_n4", {awvalid, wvalid}, 2'b01);
        at_neg(5); chk("wr_lag_n5", {awvalid, wvalid, bready}, 3'b001);
        wait_idle();
        w_dly = 0;

        issue(1'b0, REG_RST, 32'h0, 4'h1);
        expect_rsp("rd_rst", 32'h1234_5678, RESP_OKAY, 1'b0, 1'b0, 4);
        at_neg(0);
        chk("rd_rst_araddr", araddr, 32'hf000_0002);
        wait_idle();

        // Dead slave: abort 16 cycles after entering WADDR.
        dead = 1'b1;
        issue(1'b1, REG_FAR, 32'hDEAD, 4'h6);
        expect_rsp("wr_dead", 32'h0, RESP_SLVERR, 1'b1, 1'b0, 16);
        at_neg(15); chk("wr_dead_n15", {awvalid, wvalid}, 2'b11);
        at_neg(16); chk("wr_dead_n16", {awvalid, wvalid, bready, rsp_vld}, 4'b0001);
        wait_idle();
        dead = 1'b0;

        issue(1'b0, REG_FAR, 32'h0, 4'hA);
        expect_rsp("rd_after_dead", 32'h1, RESP_OKAY, 1'b0, 1'b0, 4);
        wait_idle();

        // rvalid lands in the timeout cycle and must win.
        ar_dly = 0; r_sep = 1'b1; r_dly = 14;
        issue(1'b0, REG_ERR, 32'h0, 4'h9);
        expect_rsp("rd_edge", 32'h0000_00A5, RESP_OKAY, 1'b0, 1'b0, 18);
        at_neg(2); chk("rd_edge_rdata_st", {arvalid, rready}, 2'b01);
        wait_idle();

        // Reset in RDATA aborts without a response.
        r_dly = 20;
        issue(1'b0, REG_ERR, 32'h0, 4'h4);
        at_neg(4);
        rst = 1'b0;
        #1;
        chk("rst_mid", {rready, busy, arvalid, rsp_vld, cmd_rdy}, 5'b00000);
        ar_dly = 2; r_sep = 1'b0; r_dly = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(1'b0, REG_ERR, 32'h0, 4'h8);
        expect_rsp("rd_err_post_rst", 32'h0000_00A5, RESP_OKAY, 1'b0, 1'b0, 4);
        wait_idle();

        // Slave returns rid=0 for issued id 7.
        id_force = 1'b1;
        issue(1'b0, REG_ERR, 32'h0, 4'h7);
        expect_rsp("rd_idchk", 32'h0000_00A5, RESP_OKAY, 1'b0, EXP_IDERR, 4);
        wait_idle();
        id_force = 1'b0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdn_axil_master.md
Name: fdn_axil_master

Overview:
- AXI-Lite initiator that drives the control slave of the FDN core: the Farrow-mode register, the error register and the soft-reset register.
- Accepts one command at a time on a simple valid/ready command port.
- Issues a single AXI write or read with ID, collects the response, and returns the data, the response code and any timeout on a one-cycle response strobe.
- Sits in the control subsystem between the sequencer/CPU bridge and the FDN core's s_axil port.

Parameters:
- BASE_ADDR, 32'hf0000000, block base address; issued address = BASE_ADDR | cmd_addr.
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width.
- ID_W, 4, AXI ID width.
- TIMEOUT, 1024, maximum cycles spent waiting in any handshake state before abort; must be >= 2.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register offset.
- cmd_wdata  in  DATA_W  write data.
- cmd_id  in  ID_W  transaction ID.
- rsp_vld  out  1  one-cycle response strobe.
- rsp_data  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  captured bresp/rresp.
- rsp_tout  out  1  transaction aborted by timeout.
- rsp_iderr  out  1  returned ID mismatch; only driven under FDN_AXIL_IDCHK_EN, else 0.
- busy  out  1  FSM is not in IDLE.
- m_axil_awaddr/awid/awvalid/awready, m_axil_wdata/wstrb/wvalid/wready, m_axil_bresp/bvalid/bready/bid: write channels; directions mirror the slave.
- m_axil_araddr/arid/arvalid/arready, m_axil_rdata/rresp/rvalid/rready/rid: read channels; directions mirror the slave.

Behaviour:
- Reset values (rst low, asynchronous):
  - All valids, bready, rready, rsp_vld and busy are 0.
  - cmd_rdy is 0.
  - Address, data and ID outputs are 0; wstrb is 4'hF.
  - FSM is in IDLE and the timeout counter is 0.
- cmd_rdy = 1 only in IDLE. Command fields are registered on acceptance.
- States:
  - IDLE:
    - On accepted write -> WADDR: awvalid and wvalid rise on the same edge; the slave requires both high together.
    - On accepted read -> RADDR: arvalid rises.
  - WADDR:
    - awvalid drops the cycle after awready is sampled high; wvalid drops the cycle after wready is sampled high. The two drop independently.
    - When both handshakes are done -> WRESP with bready=1.
  - WRESP: on bvalid, capture bresp and bid, drop bready -> RSP.
  - RADDR:
    - On arready, drop arvalid and raise rready.
    - If rvalid arrives in the same cycle as arready, capture rdata/rresp/rid immediately -> RSP.
    - Otherwise -> RDATA.
  - RDATA: rready=1; on rvalid, capture rdata, rresp and rid, drop rready -> RSP.
  - RSP: rsp_vld=1 for exactly one cycle -> IDLE.
- Latency:
  - Command acceptance to rsp_vld is (slave latency + 2) cycles.
  - For the FDN slave: write = 5 cycles to rsp_vld with bready held; read = 4 cycles.
- Timeout:
  - The counter clears on every state entry and increments in WADDR, WRESP, RADDR and RDATA.
  - At TIMEOUT-1: drop all valids/readies, set rsp_tout=1, rsp_resp=2'b10, rsp_data=0 -> RSP.
  - This is dead-slave recovery only; the protocol violation is accepted.
- Simultaneous events: a bvalid or rvalid arriving in the same cycle as the timeout wins; the response is taken normally and rsp_tout=0.
- A reset asserted mid-transaction aborts immediately; no response is produced.
- Address arithmetic is a bitwise OR, not an add; cmd_addr bits overlapping BASE_ADDR are OR-merged.

Optional Feature:
- FDN_AXIL_IDCHK_EN defined:
  - Captured bid/rid is compared with the issued ID.
  - A mismatch sets rsp_iderr=1 in RSP.
  - rsp_resp is left as returned.
- Undefined: bid/rid are ignored and rsp_iderr is tied to 0.

Decomposition:
- Package fdn_axil_pkg holds:
  - state enum axil_st_t {IDLE, WADDR, WRESP, RADDR, RDATA, RSP};
  - response codes RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - register offsets REG_FAR = 0, REG_ERR = 1, REG_RST = 2.
- No sub-module; the FSM and timeout counter live in a single module.

Test Plan:
- Write REG_FAR, data 1, id 4'h3, against the FDN slave model -> awaddr 32'hf0000000 with awvalid and wvalid high together; rsp_vld after 5 cycles; rsp_resp=0; bid=3.
- Read REG_FAR after that write, id 4'h5 -> arready and rvalid arrive in the same cycle; rsp_data=1; rsp_resp=0; rsp_vld after 4 cycles.
- Slave raises wready 3 cycles after awready -> awvalid drops after awready; wvalid stays high until wready; a single response follows.
- Slave never asserts bvalid, TIMEOUT=16 -> all valids low 16 cycles after entering WADDR; rsp_tout=1; rsp_resp=2'b10; next command accepted.
- rst driven low while in RDATA -> rready=0 and busy=0 asynchronously; no rsp_vld; after release, a read of REG_ERR completes normally.
- FDN_AXIL_IDCHK_EN defined, slave returns rid=4'h0 for id 4'h7 -> rsp_iderr=1; the same test without the macro gives rsp_iderr=0.
